// File: rtl/ag_uop_sequencer.sv
// AG-stage micro-op sequencer: splits one instruction into 1-3 memory micro-ops and qualifies issue into ME.
// Optional dependency-stall counter is enabled with the AG_STALL_CNT_EN macro.
// Handshake: a micro-op transfers into ME when V_ME_OUT=1 and LD_ME_OUT=1 on the same clock edge.
module ag_uop_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             V_D2,
  input  logic [1:0]       NUM_UOPS,
  input  logic             DEP_STALL,
  input  logic             SEG_LIMIT_EXC,
  input  logic             ME_STALL,
  input  logic             FLUSH,
  output logic             LD_ME_OUT,
  output logic             V_ME_OUT,
  output logic             EXC_ME_OUT,
  output logic [1:0]       UOP_IDX_OUT,
  output logic             UOP_LAST_OUT,
  output logic             D2_STALL_OUT,
`ifdef AG_STALL_CNT_EN
  output logic [CNT_W-1:0] STALL_CNT_OUT,
`endif
  output logic             BUSY_OUT
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEQ  = 2'd1;
  localparam logic [1:0] ST_EXC  = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [1:0] uop_idx;
  logic [1:0] uop_idx_nxt;
  logic [1:0] last_idx;
  logic       last;
  logic       go;

  // NUM_UOPS of 0 is treated like 1, so the final index is max(NUM_UOPS,1)-1.
  assign last_idx = (NUM_UOPS == 2'd0) ? 2'd0 : NUM_UOPS - 2'd1;
  assign last     = (uop_idx >= last_idx);
  assign go       = V_D2 & ~DEP_STALL & ~ME_STALL & ~FLUSH & (state != ST_EXC);

  // All outputs are forced low while reset is asserted.
  assign LD_ME_OUT    = RST & (~ME_STALL | FLUSH);
  assign V_ME_OUT     = RST & go;
  assign EXC_ME_OUT   = RST & go & SEG_LIMIT_EXC;
  assign UOP_IDX_OUT  = RST ? uop_idx : 2'd0;
  assign UOP_LAST_OUT = RST & go & last;
  assign BUSY_OUT     = RST & (state != ST_IDLE);
  assign D2_STALL_OUT = RST & ~FLUSH &
                        ((state == ST_EXC) | (V_D2 & ~(go & last & ~SEG_LIMIT_EXC)));

  always_comb begin
    state_nxt   = state;
    uop_idx_nxt = uop_idx;
    if (FLUSH) begin
      state_nxt   = ST_IDLE;
      uop_idx_nxt = 2'd0;
    end else if (state == ST_EXC) begin
      state_nxt   = ST_EXC;
      uop_idx_nxt = 2'd0;
    end else if ((state == ST_SEQ) && !V_D2) begin
      // Instruction vanished mid-sequence: abandon it without issuing.
      state_nxt   = ST_IDLE;
      uop_idx_nxt = 2'd0;
    end else if (go && SEG_LIMIT_EXC) begin
      state_nxt   = ST_EXC;
      uop_idx_nxt = 2'd0;
    end else if (go && last) begin
      state_nxt   = ST_IDLE;
      uop_idx_nxt = 2'd0;
    end else if (go) begin
      state_nxt   = ST_SEQ;
      uop_idx_nxt = uop_idx + 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= ST_IDLE;
      uop_idx <= 2'd0;
    end else begin
      state   <= state_nxt;
      uop_idx <= uop_idx_nxt;
    end
  end

`ifdef AG_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt <= '0;
    end else if (V_D2 && DEP_STALL && !FLUSH && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign STALL_CNT_OUT = stall_cnt;
`endif

endmodule

// File: tb/tb_ag_uop_sequencer.sv
// Bench for ag_uop_sequencer: directed vector table, multi-cycle corner sequences and a random run
// checked against an instruction-level reference model.
module tb_ag_uop_sequencer;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       V_D2 = 1'b0;
  logic [1:0] NUM_UOPS = 2'd0;
  logic       DEP_STALL = 1'b0;
  logic       SEG_LIMIT_EXC = 1'b0;
  logic       ME_STALL = 1'b0;
  logic       FLUSH = 1'b0;
  logic       LD_ME_OUT, V_ME_OUT, EXC_ME_OUT, UOP_LAST_OUT, D2_STALL_OUT, BUSY_OUT;
  logic [1:0] UOP_IDX_OUT;
`ifdef AG_STALL_CNT_EN
  logic [CNT_W-1:0] STALL_CNT_OUT;
`endif

  ag_uop_sequencer #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .V_D2(V_D2), .NUM_UOPS(NUM_UOPS), .DEP_STALL(DEP_STALL),
    .SEG_LIMIT_EXC(SEG_LIMIT_EXC), .ME_STALL(ME_STALL), .FLUSH(FLUSH),
    .LD_ME_OUT(LD_ME_OUT), .V_ME_OUT(V_ME_OUT), .EXC_ME_OUT(EXC_ME_OUT),
    .UOP_IDX_OUT(UOP_IDX_OUT), .UOP_LAST_OUT(UOP_LAST_OUT), .D2_STALL_OUT(D2_STALL_OUT),
`ifdef AG_STALL_CNT_EN
    .STALL_CNT_OUT(STALL_CNT_OUT),
`endif
    .BUSY_OUT(BUSY_OUT)
  );

  always #5 CLK = ~CLK;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: micro-ops already issued for the current instruction and a fault flag.
  int issued = 0;
  bit in_exc = 1'b0;
  int model_cnt = 0;

  typedef struct {
    logic       v;
    logic [1:0] num;
    logic       dep, seg, me, fl;
    logic [7:0] exp;  // {ld, v, exc, idx[1:0], last, d2_stall, busy}
  } vec_t;

  function automatic logic [7:0] dut_outs();
    return {LD_ME_OUT, V_ME_OUT, EXC_ME_OUT, UOP_IDX_OUT, UOP_LAST_OUT, D2_STALL_OUT, BUSY_OUT};
  endfunction

  function automatic logic [7:0] model_outs();
    int  n;
    bit  can, lst;
    logic [7:0] r;
    n   = (NUM_UOPS == 2'd0) ? 1 : int'(NUM_UOPS);
    can = V_D2 && !DEP_STALL && !ME_STALL && !FLUSH && !in_exc;
    lst = (issued + 1 >= n);
    r[7]   = !ME_STALL || FLUSH;
    r[6]   = can;
    r[5]   = can && SEG_LIMIT_EXC;
    r[4:3] = 2'(issued);
    r[2]   = can && lst;
    r[1]   = FLUSH ? 1'b0 : (in_exc || (V_D2 && !(can && lst && !SEG_LIMIT_EXC)));
    r[0]   = in_exc || (issued > 0);
    return r;
  endfunction

  task automatic model_update();
    int n;
    bit can;
    n   = (NUM_UOPS == 2'd0) ? 1 : int'(NUM_UOPS);
    can = V_D2 && !DEP_STALL && !ME_STALL && !FLUSH && !in_exc;
    if (V_D2 && DEP_STALL && !FLUSH && model_cnt < CNT_MAX) model_cnt++;
    if (FLUSH) begin
      issued = 0; in_exc = 1'b0;
    end else if (in_exc) begin
      issued = 0;
    end else if (issued > 0 && !V_D2) begin
      issued = 0;
    end else if (can && SEG_LIMIT_EXC) begin
      issued = 0; in_exc = 1'b1;
    end else if (can && issued + 1 >= n) begin
      issued = 0;
    end else if (can) begin
      issued++;
    end
  endtask

  task automatic model_reset();
    issued = 0; in_exc = 1'b0; model_cnt = 0;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b (ld v exc idx last d2 busy)", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name);
`ifdef AG_STALL_CNT_EN
    tests_run++;
    if (int'(STALL_CNT_OUT) != model_cnt) begin
      tests_failed++;
      $display("FAIL %s: stall count %0d expected %0d", name, STALL_CNT_OUT, model_cnt);
    end
`else
    if (name.len() == 0) tests_run = tests_run;
`endif
  endtask

  task automatic drive(input logic v, input logic [1:0] num, input logic dep,
                       input logic seg, input logic me, input logic fl);
    V_D2 = v; NUM_UOPS = num; DEP_STALL = dep; SEG_LIMIT_EXC = seg; ME_STALL = me; FLUSH = fl;
  endtask

  vec_t vecs[20];

  initial begin
    // Directed sequence from reset; each row is one clock.
    vecs[0]  = '{1, 1, 0, 0, 0, 0, 8'b1100_0100};  // single uop, no stall
    vecs[1]  = '{1, 3, 0, 0, 0, 0, 8'b1100_0010};  // 3 uops: idx 0
    vecs[2]  = '{1, 3, 0, 0, 0, 0, 8'b1100_1011};  // idx 1
    vecs[3]  = '{1, 3, 0, 0, 0, 0, 8'b1101_0101};  // idx 2, last
    vecs[4]  = '{1, 2, 0, 0, 0, 0, 8'b1100_0010};  // 2 uops: idx 0
    vecs[5]  = '{1, 2, 0, 0, 1, 0, 8'b0000_1011};  // ME stall at idx 1
    vecs[6]  = '{1, 2, 0, 0, 1, 0, 8'b0000_1011};
    vecs[7]  = '{1, 2, 0, 0, 0, 0, 8'b1100_1101};  // issues after stall drops
    vecs[8]  = '{1, 3, 0, 0, 0, 0, 8'b1100_0010};  // fault case: idx 0
    vecs[9]  = '{1, 3, 0, 1, 0, 0, 8'b1110_1011};  // idx 1 faults, issues with EXC
    vecs[10] = '{1, 3, 0, 0, 0, 0, 8'b1000_0011};  // EXC: nothing issues
    vecs[11] = '{1, 3, 0, 0, 0, 1, 8'b1000_0001};  // flush out of EXC
    vecs[12] = '{1, 3, 0, 0, 0, 0, 8'b1100_0010};  // flush mid-SEQ: idx 0
    vecs[13] = '{1, 3, 0, 0, 0, 0, 8'b1100_1011};  // idx 1
    vecs[14] = '{1, 3, 1, 0, 1, 1, 8'b1001_0001};  // flush beats dep/ME stall at idx 2
    vecs[15] = '{0, 3, 0, 0, 0, 0, 8'b1000_0000};  // back in IDLE, idx 0
    vecs[16] = '{1, 2, 0, 0, 0, 0, 8'b1100_0010};  // V_D2 drop mid-SEQ
    vecs[17] = '{0, 2, 0, 0, 0, 0, 8'b1000_1001};
    vecs[18] = '{0, 2, 0, 0, 0, 0, 8'b1000_0000};
    vecs[19] = '{1, 0, 0, 0, 0, 0, 8'b1100_0100};  // NUM_UOPS=0 acts as 1

    // Outputs must be zero while reset is held, whatever the inputs.
    drive(1, 3, 0, 1, 0, 1);
    #12;
    check8("reset_outputs", dut_outs(), 8'b0);
    check_cnt("reset_cnt");
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0);
    RST = 1'b1;
    model_reset();

    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      drive(vecs[i].v, vecs[i].num, vecs[i].dep, vecs[i].seg, vecs[i].me, vecs[i].fl);
      #1;
      check8($sformatf("vec%0d", i), dut_outs(), vecs[i].exp);
      @(posedge CLK);
      model_update();
    end

    // Dependency stall holds the index for a long run; counter saturates when enabled.
    @(negedge CLK);
    drive(1, 2, 0, 0, 0, 0);
    #1;
    check8("dep_pre", dut_outs(), 8'b1100_0010);
    @(posedge CLK);
    model_update();
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      drive(1, 2, 1, 0, 0, 0);
      #1;
      if (i == 19) check8("dep_hold_idx1", dut_outs(), 8'b1000_1011);
      @(posedge CLK);
      model_update();
    end
    @(negedge CLK);
    #1;
`ifdef AG_STALL_CNT_EN
    tests_run++;
    if (STALL_CNT_OUT !== 4'd15) begin
      tests_failed++;
      $display("FAIL cnt_saturate: got %0d expected 15", STALL_CNT_OUT);
    end
`endif
    // Asynchronous reset in mid-sequence clears everything without a clock edge.
    #2;
    RST = 1'b0;
    #1;
    check8("async_reset_outputs", dut_outs(), 8'b0);
    model_reset();
    check_cnt("async_reset_cnt");
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0);
    RST = 1'b1;

    // Randomised run against the reference model; NUM_UOPS changes only while V_D2 is low.
    for (int c = 0; c < 3000; c++) begin
      logic v;
      logic [1:0] num;
      @(negedge CLK);
      v   = ($urandom_range(0, 99) < 85);
      num = v ? NUM_UOPS : 2'($urandom_range(0, 3));
      drive(v, num, ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 8),
            ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 5));
      #1;
      check8($sformatf("rand%0d", c), dut_outs(), model_outs());
      check_cnt($sformatf("rand_cnt%0d", c));
      @(posedge CLK);
      model_update();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
